ms_enc_scheduler: RTL and testbench
===================================

Name: ms_enc_scheduler

Overview:
- Sequences the multi-symbol range encoder core over a symbol stream of arbitrary length.
- Packs incoming 8-bit symbols into 40-bit chunks of up to 5 symbols, holds the encoder in reset between chunks, then launches it.
- Waits for its finish flag, counts the bytes it writes to output BRAM, and reports overall completion.
- Sits between the symbol source (valid/ready) and the encoder core.

Parameters:
- SYMS_PER_CHUNK, 5, symbols packed per encoder launch (chunk width = 8*SYMS_PER_CHUNK = 40).
- ENC_RST_CYCLES, 2, cycles o_enc_rst_n is held low before each launch.
- TIMEOUT, 1024, maximum cycles in RUN before the timeout error.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  synchronous active-low reset
- i_start  in  1  start pulse, sampled in IDLE only
- i_len  in  32  total symbols to encode, latched on accepted i_start
- i_sym_valid  in  1  symbol available
- i_sym  in  8  symbol value
- o_sym_ready  out  1  symbol accepted when valid&ready
- o_enc_rst_n  out  1  encoder reset, active-low
- o_enc_en  out  1  encoder enable
- o_enc_data  out  40  packed chunk; symbol k at bits [8k+7:8k]
- o_enc_size  out  32  symbol count of current chunk (1..5)
- i_enc_finish  in  1  encoder finish flag; level, stays high until encoder reset
- i_enc_we  in  1  encoder output-BRAM write strobe
- o_busy  out  1  high in every state except IDLE
- o_done  out  1  one-cycle completion pulse
- o_chunk_cnt  out  16  chunks completed in current job
- o_byte_cnt  out  32  encoder bytes written in current job
- o_err_timeout  out  1  sticky timeout flag

Behaviour:
- Reset values: o_sym_ready=0, o_enc_rst_n=0, o_enc_en=0, o_enc_data=0, o_enc_size=0, o_busy=0, o_done=0, o_chunk_cnt=0, o_byte_cnt=0, o_err_timeout=0, state=IDLE, remaining=0.
- Reset mid-operation aborts the job immediately; the encoder is held in reset while i_rst_n=0.
- IDLE:
  - o_enc_rst_n=0.
  - On i_start: latch remaining=i_len; clear o_chunk_cnt, o_byte_cnt, o_err_timeout.
  - If i_len==0, go to DONE; otherwise go to FILL.
  - i_start in any other state is ignored.
- FILL:
  - o_sym_ready=1 while fill_cnt < target, where target = min(SYMS_PER_CHUNK, remaining).
  - Each valid&ready writes i_sym into byte lane fill_cnt of o_enc_data, then fill_cnt++.
  - Unused upper lanes are 0.
  - o_sym_ready drops in the cycle after the last accept (no over-accept).
  - When fill_cnt==target: o_enc_size=target, go to LAUNCH.
- LAUNCH:
  - o_enc_rst_n=0 and o_enc_en=0 for exactly ENC_RST_CYCLES cycles.
  - o_enc_data and o_enc_size are held stable, then go to RUN.
- RUN:
  - o_enc_rst_n=1, o_enc_en=1. o_enc_data and o_enc_size stay stable throughout.
  - Every cycle with i_enc_we=1 increments o_byte_cnt by 1 (wraps at 2^32).
  - i_enc_finish==1 ends the chunk: o_chunk_cnt++, remaining -= o_enc_size, fill_cnt=0.
    - If remaining==0, go to DONE; otherwise go to FILL.
  - A finish and a we in the same cycle both count.
  - The timeout counter clears on RUN entry. If it reaches TIMEOUT without finish: o_err_timeout=1 and go to DONE; the chunk is not counted.
- DONE:
  - o_done=1 for one cycle, o_enc_en=0, o_enc_rst_n=0, then go to IDLE.
  - Counters hold their values until the next accepted i_start.
- Write strobes arriving outside RUN are ignored.
- Latency: the first o_enc_en assertion occurs exactly ENC_RST_CYCLES+1 cycles after the last symbol of a chunk is accepted.

Test Plan:
- i_len=5, symbols 0x11..0x55 back-to-back -> o_enc_data=0x5544332211, o_enc_size=5; finish after 20 cycles with 4 we pulses -> o_chunk_cnt=1, o_byte_cnt=4, single o_done pulse.
- i_len=12 -> chunks of sizes 5, 5, 2; third chunk o_enc_data upper 3 lanes zero; o_chunk_cnt=3; o_sym_ready never high after the 12th accept.
- i_len=0 -> o_done one cycle after i_start; o_enc_en never asserted; counters 0.
- i_sym_valid toggled randomly with i_len=7 -> all 7 symbols packed in order; no symbol dropped or duplicated; o_enc_rst_n low exactly 2 cycles before each launch.
- i_enc_finish held 0 -> o_err_timeout=1 after 1024 RUN cycles, o_done pulse, return to IDLE; next i_start clears the flag.
- i_rst_n=0 for 1 cycle during RUN -> all outputs return to reset values next cycle; i_start during RUN or FILL ignored.

Source files
------------

// File: rtl/ms_enc_scheduler.sv
// ms_enc_scheduler
// Feeds the multi-symbol range encoder core from a valid/ready symbol stream.
// Symbols are packed into chunks of up to SYMS_PER_CHUNK bytes, the encoder is
// held in reset for ENC_RST_CYCLES, then run until it raises its finish flag.
// Output-BRAM write strobes are counted per job, and a RUN phase that never
// finishes is abandoned after TIMEOUT cycles with a sticky error flag.
module ms_enc_scheduler #(
    parameter int SYMS_PER_CHUNK = 5,
    parameter int ENC_RST_CYCLES = 2,
    parameter int TIMEOUT        = 1024
) (
    input  logic                        i_clk,
    input  logic                        i_rst_n,
    input  logic                        i_start,
    input  logic [31:0]                 i_len,
    input  logic                        i_sym_valid,
    input  logic [7:0]                  i_sym,
    output logic                        o_sym_ready,
    output logic                        o_enc_rst_n,
    output logic                        o_enc_en,
    output logic [8*SYMS_PER_CHUNK-1:0] o_enc_data,
    output logic [31:0]                 o_enc_size,
    input  logic                        i_enc_finish,
    input  logic                        i_enc_we,
    output logic                        o_busy,
    output logic                        o_done,
    output logic [15:0]                 o_chunk_cnt,
    output logic [31:0]                 o_byte_cnt,
    output logic                        o_err_timeout
);

    localparam int CW = 8 * SYMS_PER_CHUNK;
    localparam int FW = $clog2(SYMS_PER_CHUNK + 1);
    localparam int LW = (ENC_RST_CYCLES > 1) ? $clog2(ENC_RST_CYCLES) : 1;
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FILL,
        ST_LAUNCH,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t          r_state;
    logic [31:0]     r_remaining;
    logic [FW-1:0]   r_fill_cnt;
    logic [LW-1:0]   r_launch_cnt;
    logic [TW-1:0]   r_timer;
    logic            r_sym_ready;
    logic            r_enc_rst_n;
    logic            r_enc_en;
    logic [CW-1:0]   r_enc_data;
    logic [31:0]     r_enc_size;
    logic            r_busy;
    logic            r_done;
    logic [15:0]     r_chunk_cnt;
    logic [31:0]     r_byte_cnt;
    logic            r_err_timeout;

    logic [FW-1:0]   w_target;
    logic [FW-1:0]   w_fill_next;
    logic            w_accept;
    logic [31:0]     w_rem_after;

    // Chunk size for the current fill: a full chunk, or whatever is left of the job.
    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_target = FW'(SYMS_PER_CHUNK);
        if (r_remaining < 32'(SYMS_PER_CHUNK)) begin
            w_target = r_remaining[FW-1:0];
        end
    end

    assign w_accept    = r_sym_ready & i_sym_valid;
    assign w_fill_next = r_fill_cnt + FW'(1);
    assign w_rem_after = r_remaining - r_enc_size;

    // Scheduler FSM; every output is registered so the encoder sees glitch-free controls.
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_remaining   <= '0;
            r_fill_cnt    <= '0;
            r_launch_cnt  <= '0;
            r_timer       <= '0;
            r_sym_ready   <= 1'b0;
            r_enc_rst_n   <= 1'b0;
            r_enc_en      <= 1'b0;
            r_enc_data    <= '0;
            r_enc_size    <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_chunk_cnt   <= '0;
            r_byte_cnt    <= '0;
            r_err_timeout <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_enc_rst_n <= 1'b0;
                    r_enc_en    <= 1'b0;
                    r_sym_ready <= 1'b0;
                    if (i_start) begin
                        r_remaining   <= i_len;
                        r_chunk_cnt   <= '0;
                        r_byte_cnt    <= '0;
                        r_err_timeout <= 1'b0;
                        r_fill_cnt    <= '0;
                        r_enc_data    <= '0;
                        r_busy        <= 1'b1;
                        if (i_len == 32'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_FILL;
                            r_sym_ready <= 1'b1;
                        end
                    end
                end

                ST_FILL: begin
                    if (w_accept) begin
                        for (int k = 0; k < SYMS_PER_CHUNK; k++) begin
                            if (r_fill_cnt == FW'(k)) begin
                                r_enc_data[8*k +: 8] <= i_sym;
                            end
                        end
                        r_fill_cnt <= w_fill_next;
                        // The last accept of the chunk closes the fill immediately so
                        // ready drops next cycle and the launch latency stays fixed.
                        if (w_fill_next == w_target) begin
                            r_sym_ready  <= 1'b0;
                            r_enc_size   <= 32'(w_target);
                            r_launch_cnt <= '0;
                            r_state      <= ST_LAUNCH;
                        end
                    end
                end

                ST_LAUNCH: begin
                    r_enc_rst_n <= 1'b0;
                    r_enc_en    <= 1'b0;
                    if (r_launch_cnt == LW'(ENC_RST_CYCLES - 1)) begin
                        r_enc_rst_n <= 1'b1;
                        r_enc_en    <= 1'b1;
                        r_timer     <= '0;
                        r_state     <= ST_RUN;
                    end else begin
                        r_launch_cnt <= r_launch_cnt + LW'(1);
                    end
                end

                ST_RUN: begin
                    if (i_enc_we) begin
                        r_byte_cnt <= r_byte_cnt + 32'd1;
                    end
                    if (i_enc_finish) begin
                        r_chunk_cnt <= r_chunk_cnt + 16'd1;
                        r_remaining <= w_rem_after;
                        r_fill_cnt  <= '0;
                        r_enc_rst_n <= 1'b0;
                        r_enc_en    <= 1'b0;
                        if (w_rem_after == 32'd0) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= ST_FILL;
                            r_sym_ready <= 1'b1;
                            r_enc_data  <= '0;
                        end
                    end else if (r_timer == TW'(TIMEOUT - 1)) begin
                        // Encoder never finished: abandon the job, chunk not counted.
                        r_err_timeout <= 1'b1;
                        r_enc_rst_n   <= 1'b0;
                        r_enc_en      <= 1'b0;
                        r_state       <= ST_DONE;
                        r_done        <= 1'b1;
                    end else begin
                        r_timer <= r_timer + TW'(1);
                    end
                end

                ST_DONE: begin
                    r_enc_rst_n <= 1'b0;
                    r_enc_en    <= 1'b0;
                    r_sym_ready <= 1'b0;
                    r_busy      <= 1'b0;
                    r_state     <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_sym_ready   = r_sym_ready;
    assign o_enc_rst_n   = r_enc_rst_n;
    assign o_enc_en      = r_enc_en;
    assign o_enc_data    = r_enc_data;
    assign o_enc_size    = r_enc_size;
    assign o_busy        = r_busy;
    assign o_done        = r_done;
    assign o_chunk_cnt   = r_chunk_cnt;
    assign o_byte_cnt    = r_byte_cnt;
    assign o_err_timeout = r_err_timeout;

endmodule

// File: tb/tb_ms_enc_scheduler.sv
// Self-checking bench for ms_enc_scheduler: a table of directed jobs, a few
// randomized jobs, and hand-written reset sequences. Expected chunk contents
// come from slicing the job's symbol list into groups of SYMS_PER_CHUNK.
`timescale 1ns/1ps
module tb_ms_enc_scheduler;

    localparam int SPC  = 5;
    localparam int RSTC = 2;
    localparam int TMO  = 1024;
    localparam int BUDGET = 3000;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_start;
    logic [31:0] i_len;
    logic        i_sym_valid;
    logic [7:0]  i_sym;
    logic        o_sym_ready;
    logic        o_enc_rst_n;
    logic        o_enc_en;
    logic [39:0] o_enc_data;
    logic [31:0] o_enc_size;
    logic        i_enc_finish;
    logic        i_enc_we;
    logic        o_busy;
    logic        o_done;
    logic [15:0] o_chunk_cnt;
    logic [31:0] o_byte_cnt;
    logic        o_err_timeout;

    int n_checks = 0;
    int n_errors = 0;

    always #5 i_clk = ~i_clk;

    ms_enc_scheduler #(
        .SYMS_PER_CHUNK(SPC),
        .ENC_RST_CYCLES(RSTC),
        .TIMEOUT       (TMO)
    ) dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .i_start      (i_start),
        .i_len        (i_len),
        .i_sym_valid  (i_sym_valid),
        .i_sym        (i_sym),
        .o_sym_ready  (o_sym_ready),
        .o_enc_rst_n  (o_enc_rst_n),
        .o_enc_en     (o_enc_en),
        .o_enc_data   (o_enc_data),
        .o_enc_size   (o_enc_size),
        .i_enc_finish (i_enc_finish),
        .i_enc_we     (i_enc_we),
        .o_busy       (o_busy),
        .o_done       (o_done),
        .o_chunk_cnt  (o_chunk_cnt),
        .o_byte_cnt   (o_byte_cnt),
        .o_err_timeout(o_err_timeout)
    );

    typedef struct {
        int len;
        int valid_pct;
        int fin_delay;   // RUN cycles before the encoder model raises finish
        int we_n;        // write strobes issued at the start of each RUN
        bit hang;        // encoder never finishes
        bit ramp_syms;   // symbols 0x11, 0x22, ... instead of random
        bit poke_start;  // pulse i_start while busy
        int exp_chunks;
        int exp_bytes;
        bit exp_err;
    } job_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, " sym_ready"},   64'(o_sym_ready),   64'd0);
        check({tag, " enc_rst_n"},   64'(o_enc_rst_n),   64'd0);
        check({tag, " enc_en"},      64'(o_enc_en),      64'd0);
        check({tag, " enc_data"},    64'(o_enc_data),    64'd0);
        check({tag, " enc_size"},    64'(o_enc_size),    64'd0);
        check({tag, " busy"},        64'(o_busy),        64'd0);
        check({tag, " done"},        64'(o_done),        64'd0);
        check({tag, " chunk_cnt"},   64'(o_chunk_cnt),   64'd0);
        check({tag, " byte_cnt"},    64'(o_byte_cnt),    64'd0);
        check({tag, " err_timeout"}, 64'(o_err_timeout), 64'd0);
    endtask

    task automatic run_job(input job_t j, input string tag);
        logic [7:0]  syms[$];
        logic [39:0] exp_data[$];
        int          exp_size[$];
        logic [39:0] got_data[$];
        int          got_size[$];
        int sent = 0, last_acc = -100, run = 0, done_cnt = 0, en_cycles = 0;
        int lat_bad = 0, stab_bad = 0, over_bad = 0, rst_bad = 0;
        int nchunks, nlaunch, exp_en_cycles, cyc;
        bit prev_en = 1'b0, p1_rstn = 1'b1, p2_rstn = 1'b1, done_seen = 1'b0;

        // Reference: slice the symbol list into chunks, pack lane k = symbol k.
        for (int i = 0; i < j.len; i++) begin
            syms.push_back(j.ramp_syms ? 8'((i + 1) * 17) : 8'($urandom));
        end
        for (int base = 0; base < j.len; base += SPC) begin
            int n;
            logic [39:0] d;
            n = (j.len - base < SPC) ? j.len - base : SPC;
            d = '0;
            for (int k = 0; k < n; k++) d = d | (40'(syms[base + k]) << (8 * k));
            exp_data.push_back(d);
            exp_size.push_back(n);
        end
        nchunks       = exp_data.size();
        nlaunch       = (j.hang && nchunks > 0) ? 1 : nchunks;
        exp_en_cycles = j.hang ? ((nchunks > 0) ? TMO : 0) : nchunks * j.fin_delay;

        @(negedge i_clk);
        i_start = 1'b1;
        i_len   = 32'(j.len);
        @(negedge i_clk);
        i_start = 1'b0;

        for (cyc = 0; cyc < BUDGET && !done_seen; cyc++) begin
            if (cyc == 0) begin
                check({tag, " busy after start"},  64'(o_busy),        64'd1);
                check({tag, " err cleared"},       64'(o_err_timeout), 64'd0);
                check({tag, " chunk_cnt cleared"}, 64'(o_chunk_cnt),   64'd0);
                check({tag, " byte_cnt cleared"},  64'(o_byte_cnt),    64'd0);
            end
            if (o_done) begin
                done_cnt++;
                done_seen = 1'b1;
            end
            if (o_enc_en) begin
                en_cycles++;
                if (!prev_en) begin
                    got_data.push_back(o_enc_data);
                    got_size.push_back(int'(o_enc_size));
                    if (cyc - last_acc != RSTC + 1) lat_bad++;
                    if (p1_rstn || p2_rstn || !o_enc_rst_n) rst_bad++;
                end else if (o_enc_data !== got_data[$] || int'(o_enc_size) != got_size[$]) begin
                    stab_bad++;
                end
            end
            if (o_sym_ready && (sent >= j.len || o_enc_en)) over_bad++;

            // Symbol source with random valid gaps.
            i_sym_valid = 1'b0;
            i_sym       = 8'($urandom);
            if (sent < j.len && $urandom_range(99) < j.valid_pct) begin
                i_sym_valid = 1'b1;
                i_sym       = syms[sent];
                if (o_sym_ready) begin
                    sent++;
                    last_acc = cyc;
                end
            end

            // Encoder core model: idle in reset (stray strobes), runs while enabled.
            i_enc_we = 1'b0;
            if (!o_enc_rst_n) begin
                i_enc_finish = 1'b0;
                run          = 0;
                i_enc_we     = 1'($urandom);
            end else if (o_enc_en) begin
                run++;
                if (run <= j.we_n) i_enc_we = 1'b1;
                if (!j.hang && run >= j.fin_delay) i_enc_finish = 1'b1;
            end

            i_start = 1'b0;
            if (j.poke_start && o_busy && !o_done && $urandom_range(3) == 0) begin
                i_start = 1'b1;
                i_len   = 32'd3;
            end

            prev_en = o_enc_en;
            p2_rstn = p1_rstn;
            p1_rstn = o_enc_rst_n;
            @(negedge i_clk);
        end

        i_start     = 1'b0;
        i_sym_valid = 1'b0;
        i_enc_we    = 1'b0;
        check({tag, " done reached"}, 64'(done_seen), 64'd1);
        check({tag, " chunk_cnt"},    64'(o_chunk_cnt),   64'(j.exp_chunks));
        check({tag, " byte_cnt"},     64'(o_byte_cnt),    64'(j.exp_bytes));
        check({tag, " err_timeout"},  64'(o_err_timeout), 64'(j.exp_err));
        check({tag, " idle busy"},    64'(o_busy),        64'd0);
        for (int k = 0; k < 3; k++) begin
            if (o_done) done_cnt++;
            @(negedge i_clk);
        end
        check({tag, " done pulses"},  64'(done_cnt),  64'd1);
        check({tag, " launches"},     64'(got_data.size()), 64'(nlaunch));
        for (int k = 0; k < nlaunch && k < got_data.size(); k++) begin
            check($sformatf("%s chunk%0d data", tag, k), 64'(got_data[k]), 64'(exp_data[k]));
            check($sformatf("%s chunk%0d size", tag, k), 64'(got_size[k]), 64'(exp_size[k]));
        end
        check({tag, " en cycles"},     64'(en_cycles), 64'(exp_en_cycles));
        check({tag, " launch latency"}, 64'(lat_bad),  64'd0);
        check({tag, " enc_rst_n window"}, 64'(rst_bad), 64'd0);
        check({tag, " data stable"},   64'(stab_bad),  64'd0);
        check({tag, " no over-ready"}, 64'(over_bad),  64'd0);
    endtask

    initial begin
        job_t jobs[6];
        job_t r;

        //        len valid fin  we hang ramp poke chunks bytes err
        jobs[0] = '{5,  100, 20,  4, 1'b0, 1'b1, 1'b0, 1, 4, 1'b0};
        jobs[1] = '{12, 100,  6,  2, 1'b0, 1'b1, 1'b1, 3, 6, 1'b0};
        jobs[2] = '{0,  100,  5,  3, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0};
        jobs[3] = '{7,   50,  3,  3, 1'b0, 1'b0, 1'b1, 2, 6, 1'b0};
        jobs[4] = '{5,  100,  0,  3, 1'b1, 1'b1, 1'b1, 0, 3, 1'b1};
        jobs[5] = '{3,  100,  1,  1, 1'b0, 1'b0, 1'b0, 1, 1, 1'b0};

        i_rst_n      = 1'b0;
        i_start      = 1'b0;
        i_len        = '0;
        i_sym_valid  = 1'b0;
        i_sym        = '0;
        i_enc_finish = 1'b0;
        i_enc_we     = 1'b0;
        repeat (3) @(negedge i_clk);
        check_reset_vals("reset");
        i_rst_n = 1'b1;
        @(negedge i_clk);

        for (int t = 0; t < 6; t++) begin
            run_job(jobs[t], $sformatf("job%0d", t));
        end

        // Reset pulse in the middle of RUN aborts the job on the next edge.
        begin
            bit reached = 1'b0;
            @(negedge i_clk);
            i_start = 1'b1;
            i_len   = 32'd10;
            for (int k = 0; k < 40 && !reached; k++) begin
                @(negedge i_clk);
                i_start     = 1'b0;
                i_sym_valid = 1'b1;
                i_sym       = 8'hA5;
                i_enc_we    = 1'b1;
                if (o_enc_en) reached = 1'b1;
            end
            check("midrun reached RUN", 64'(reached), 64'd1);
            @(negedge i_clk);
            i_rst_n = 1'b0;
            @(negedge i_clk);
            i_rst_n     = 1'b1;
            i_sym_valid = 1'b0;
            i_enc_we    = 1'b0;
            check_reset_vals("midrun reset");
            repeat (2) @(negedge i_clk);
            check("midrun stays idle", 64'(o_busy), 64'd0);
        end

        for (int t = 0; t < 6; t++) begin
            r.len        = int'($urandom_range(1, 23));
            r.valid_pct  = int'($urandom_range(30, 100));
            r.fin_delay  = int'($urandom_range(1, 25));
            r.we_n       = int'($urandom_range(0, 30));
            r.hang       = 1'b0;
            r.ramp_syms  = 1'b0;
            r.poke_start = 1'($urandom);
            r.exp_chunks = (r.len + SPC - 1) / SPC;
            r.exp_bytes  = r.exp_chunks * ((r.we_n < r.fin_delay) ? r.we_n : r.fin_delay);
            r.exp_err    = 1'b0;
            run_job(r, $sformatf("rand%0d", t));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
